fp_accumulator: RTL and testbench
=================================

# fp_accumulator

Streaming FP32 reduction stage that sits directly downstream of the FP32 add/sub stage in the VGG16 convolution datapath. It sums groups of `N_TERMS` consecutive valid FP32 values, for example the nine products of a 3x3 kernel window or per-channel partial sums. Each completed sum is emitted as a one-cycle `valid_out` pulse to the activation/pooling stage. Accumulation runs at one term per clock with no stalls, and groups may follow back-to-back.

## Interface
- `N_TERMS`, default 9: number of terms per group; legal range 1..1024.
- `CNT_W`, default `$clog2(N_TERMS)` (minimum 1): width of the term counter.

- `clk`  in  1  rising-edge clock for all state.
- `reset`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  `data_in` holds a term this cycle.
- `data_in`  in  32  IEEE-754 single-precision term.
- `bias_in`  in  32  group seed; sampled only on the first term of a group (present only with `FP_ACC_BIAS_EN`).
- `flush`  in  1  synchronous abort of the partial group.
- `sum_out`  out  32  last completed group sum.
- `valid_out`  out  1  one-cycle pulse; `sum_out` is new.
- `busy`  out  1  a partial group is open (`cnt != 0`).

## Operation
- State: `acc[31:0]`, `cnt[CNT_W-1:0]`, `sum_out` register, `valid_out` register.
- FSM with 2 states, derived from `cnt`:
  - IDLE: `cnt == 0`.
  - ACCUM: `cnt` in 1..N_TERMS-1.
- Adder operand A: the seed when `cnt == 0`, otherwise `acc`. Operand B: `data_in`.
  - Seed is +0.0 (`0x00000000`), or `bias_in` with `FP_ACC_BIAS_EN`.
- On `valid_in` with `cnt < N_TERMS-1`: `acc <= A+B`, `cnt <= cnt+1`.
- On `valid_in` with `cnt == N_TERMS-1`:
  - `sum_out <= A+B` and `valid_out <= 1`.
  - `cnt <= 0`; `acc` is don't-care.
  - The next valid term starts a new group on the very next cycle.
- `N_TERMS == 1`: every valid term produces `sum_out = seed + data_in`.
- Without `valid_in`: `acc` and `cnt` hold. `valid_out <= 0`. `sum_out` holds its last value.
- `flush` (priority over `valid_in`):
  - `cnt <= 0` and `acc <= 0`; the concurrent term is dropped.
  - No `valid_out` is generated and `sum_out` is unchanged.
- Arithmetic is the codebase's combinational FP32 adder (round/denormal/NaN behaviour inherited). No accumulation in wider precision.
- Counter never exceeds `N_TERMS-1`. Wrap-around occurs only through the group-completion path.

## Timing
- Reset values: `sum_out = 0x00000000`, `valid_out = 0`, `busy = 0`, `acc = 0`, `cnt = 0`.
- Throughput: 1 term/clock, no backpressure; upstream must not rely on a ready signal.
- Latency: `valid_out` rises the cycle after the edge that sampled the final term. `sum_out` is valid in that same cycle.
- `valid_out` is high for exactly one cycle per completed group. Back-to-back groups give pulses spaced exactly `N_TERMS` cycles apart.
- `busy` is combinational from `cnt`.
- Reset asserted mid-group: immediate clear. The partial group is lost and no `valid_out` is produced.
- Critical path: `acc` register -> FP adder -> `acc`/`sum_out`; single cycle by design.

## Configuration
- `FP_ACC_BIAS_EN` defined:
  - The `bias_in` port exists.
  - The first term of each group is added to `bias_in`, sampled in that term's cycle.
- Not defined:
  - The `bias_in` port is absent.
  - The seed is the constant +0.0, so the output is the pure sum of the terms.

## Structure
- Shared package/header `fp_defs`:
  - `FP_W = 32`.
  - `FP_ZERO = 32'h00000000`.
  - FP32 field widths (sign 1, exponent 8, mantissa 23).
- Single sub-module: the existing combinational FP32 adder `FP_cong`, instantiated once. Operand A is driven by the seed/`acc` mux.
- Counter, operand mux and output registers are inline in `fp_accumulator`.

## Test plan
- Reset, then 9 consecutive `1.0` (`0x3F800000`) -> one `valid_out` pulse one cycle after the last term, `sum_out = 0x41100000` (9.0), `busy` low afterwards.
- Two back-to-back groups: nine `1.0`, then nine `2.0` (`0x40000000`) -> pulses 9 cycles apart with `0x41100000` then `0x41900000` (18.0).
- Gapped input: nine `1.0` with random idle cycles between terms -> same `0x41100000`, exactly one pulse, `sum_out` held between groups.
- Flush after 4 terms of `3.0` (`0x40400000`), with `valid_in` high in the flush cycle -> no pulse. Then the next nine `-1.0` (`0xBF800000`) -> `sum_out = 0xC1100000`.
- Assert `reset` after 5 terms -> all outputs return to reset values immediately. Nine further `1.0` -> `0x41100000`.
- With `FP_ACC_BIAS_EN`: `bias_in = 0.5` (`0x3F000000`) and nine `1.0` -> `sum_out = 0x41180000` (9.5). With `N_TERMS = 1`, input `2.0` and bias `0.5` -> `0x40200000` every cycle.

Source files
------------

// File: rtl/fp_accumulator_pkg.sv
// ============================================================================
// Module      : fp_accumulator_pkg
// Description : Shared FP32 definitions for the accumulator slice: word and
//               field widths, well-known encodings, the accumulator state
//               encoding and small classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_accumulator_pkg;

  // FP32 word and field widths
  localparam int FP_W      = 32;
  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MAN_W  = 23;

  // Well-known encodings
  localparam logic [FP_W-1:0]     FP_ZERO    = 32'h00000000;
  localparam logic [FP_W-1:0]     FP_QNAN    = 32'h7FC00000;
  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

  // Accumulator state, derived from the term counter
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,   // no partial group open
    ST_ACCUM = 1'b1    // at least one term of the group absorbed
  } acc_state_t;

  // True for any NaN encoding (quiet or signalling)
  function automatic logic fp_is_nan(input logic [FP_W-1:0] x);
    return (x[FP_W-2 -: FP_EXP_W] == FP_EXP_MAX) && (x[FP_MAN_W-1:0] != '0);
  endfunction

  // True for +/- infinity
  function automatic logic fp_is_inf(input logic [FP_W-1:0] x);
    return (x[FP_W-2 -: FP_EXP_W] == FP_EXP_MAX) && (x[FP_MAN_W-1:0] == '0);
  endfunction

endpackage : fp_accumulator_pkg

`default_nettype wire

// File: rtl/fp_accumulator_if.sv
// ============================================================================
// Module      : fp_accumulator_if
// Description : Term-stream and result bus of the FP32 accumulator. The
//               master drives terms/flush (and the bias seed when the
//               FP_ACC_BIAS_EN macro is defined); the slave returns results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_accumulator_if;
  import fp_accumulator_pkg::*;

  logic            valid_in;
  logic [FP_W-1:0] data_in;
`ifdef FP_ACC_BIAS_EN
  logic [FP_W-1:0] bias_in;
`endif
  logic            flush;
  logic [FP_W-1:0] sum_out;
  logic            valid_out;
  logic            busy;

`ifdef FP_ACC_BIAS_EN
  modport master (output valid_in, data_in, bias_in, flush,
                  input  sum_out, valid_out, busy);
  modport slave  (input  valid_in, data_in, bias_in, flush,
                  output sum_out, valid_out, busy);
`else
  modport master (output valid_in, data_in, flush,
                  input  sum_out, valid_out, busy);
  modport slave  (input  valid_in, data_in, flush,
                  output sum_out, valid_out, busy);
`endif

endinterface : fp_accumulator_if

`default_nettype wire

// File: rtl/fp_accumulator_fpadd.sv
// ============================================================================
// Module      : FP_cong
// Description : Combinational IEEE-754 single-precision adder.
//               Round-to-nearest-even, gradual underflow (denormal in and
//               out), overflow to infinity, any NaN input or inf-inf gives
//               the canonical quiet NaN. x + (-x) gives +0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module FP_cong
  import fp_accumulator_pkg::*;
(
  input  wire logic [FP_W-1:0] i_a,
  input  wire logic [FP_W-1:0] i_b,
  output logic      [FP_W-1:0] o_sum
);

  logic        w_sa, w_sb, w_sl, w_ss;
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_fa, w_fb;
  logic [9:0]  w_ea_eff, w_eb_eff, w_el, w_es;
  logic [23:0] w_ma, w_mb, w_ml, w_ms;
  logic [9:0]  w_diff;
  logic [26:0] w_ml_x, w_ms_x, w_ms_sh;
  logic        w_sticky;
  logic [27:0] w_raw;
  logic [26:0] w_norm;
  logic [9:0]  w_exp;
  logic [4:0]  w_lz;
  logic [9:0]  w_lshift;
  logic        w_rnd;
  logic [24:0] w_mant_r;
  logic [9:0]  w_exp_f;
  logic [FP_W-1:0] w_res;

  // Align, add/subtract, normalise and round; special operands override
  always_comb begin
    // unpack; denormals use exponent 1 with no hidden bit
    w_sa     = i_a[31];
    w_sb     = i_b[31];
    w_ea     = i_a[30:23];
    w_eb     = i_b[30:23];
    w_fa     = i_a[22:0];
    w_fb     = i_b[22:0];
    w_ea_eff = (w_ea == 8'd0) ? 10'd1 : {2'b00, w_ea};
    w_eb_eff = (w_eb == 8'd0) ? 10'd1 : {2'b00, w_eb};
    w_ma     = {(w_ea != 8'd0), w_fa};
    w_mb     = {(w_eb != 8'd0), w_fb};

    // order operands so L has the larger magnitude
    if ({w_ea, w_fa} >= {w_eb, w_fb}) begin
      w_sl = w_sa; w_el = w_ea_eff; w_ml = w_ma;
      w_ss = w_sb; w_es = w_eb_eff; w_ms = w_mb;
    end else begin
      w_sl = w_sb; w_el = w_eb_eff; w_ml = w_mb;
      w_ss = w_sa; w_es = w_ea_eff; w_ms = w_ma;
    end

    // three extra bits below the LSB: guard, round, sticky
    w_diff  = w_el - w_es;
    w_ml_x  = {w_ml, 3'b000};
    w_ms_x  = {w_ms, 3'b000};
    if (w_diff >= 10'd27) begin
      w_ms_sh  = '0;
      w_sticky = |w_ms_x;
    end else begin
      w_ms_sh  = w_ms_x >> w_diff;
      w_sticky = |(w_ms_x & ((27'd1 << w_diff) - 27'd1));
    end
    w_ms_sh = w_ms_sh | {26'd0, w_sticky};

    if (w_sl ^ w_ss)
      w_raw = {1'b0, w_ml_x} - {1'b0, w_ms_sh};
    else
      w_raw = {1'b0, w_ml_x} + {1'b0, w_ms_sh};

    // normalise: right by one on carry-out, else left but never below exp 1
    w_lz     = 5'd27;
    w_lshift = 10'd0;
    w_exp    = w_el;
    w_norm   = w_raw[26:0];
    if (w_raw[27]) begin
      w_norm = w_raw[27:1] | {26'd0, w_raw[0]};
      w_exp  = w_el + 10'd1;
    end else begin
      for (int i = 0; i < 27; i++) begin
        if (w_raw[i]) w_lz = 5'(26 - i);
      end
      w_lshift = ({5'd0, w_lz} < (w_el - 10'd1)) ? {5'd0, w_lz} : (w_el - 10'd1);
      w_norm   = w_raw[26:0] << w_lshift;
      w_exp    = w_el - w_lshift;
    end

    // round to nearest, ties to even
    w_rnd    = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mant_r = {1'b0, w_norm[26:3]} + {24'd0, w_rnd};
    // carry out bumps the exponent; no hidden bit means a denormal result
    w_exp_f  = w_mant_r[24] ? (w_exp + 10'd1) : (w_mant_r[23] ? w_exp : 10'd0);

    if (w_exp_f >= 10'd255)
      w_res = {w_sl, FP_EXP_MAX, 23'd0};
    else
      w_res = {w_sl, w_exp_f[7:0], (w_mant_r[24] ? w_mant_r[23:1] : w_mant_r[22:0])};

    // exact zero: negative only when both operands are negative
    if (w_raw == 28'd0)
      w_res = {(w_sl & w_ss), 31'd0};

    // special operands
    if (fp_is_nan(i_a) || fp_is_nan(i_b) ||
        (fp_is_inf(i_a) && fp_is_inf(i_b) && (w_sa != w_sb)))
      w_res = FP_QNAN;
    else if (fp_is_inf(i_a))
      w_res = i_a;
    else if (fp_is_inf(i_b))
      w_res = i_b;
  end

  assign o_sum = w_res;

endmodule : FP_cong

`default_nettype wire

// File: rtl/fp_accumulator.sv
// ============================================================================
// Module      : fp_accumulator
// Description : Streaming FP32 reduction. Sums groups of N_TERMS consecutive
//               valid terms at one term per clock and emits each sum with a
//               one-cycle valid_out pulse. flush aborts an open group.
//               Optional macro FP_ACC_BIAS_EN: seed each group with bias_in
//               instead of +0.0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_accumulator
  import fp_accumulator_pkg::*;
#(
  parameter int N_TERMS = 9,
  parameter int CNT_W   = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
  input  wire logic       clk,
  input  wire logic       reset,
  fp_accumulator_if.slave bus
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_TERMS - 1);

  logic [FP_W-1:0]  r_acc, r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;

  logic [FP_W-1:0]  w_acc_nxt, w_sum_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_valid_nxt;

  acc_state_t       w_state;
  logic [FP_W-1:0]  w_seed, w_op_a, w_add;

`ifdef FP_ACC_BIAS_EN
  assign w_seed = bus.bias_in;
`else
  assign w_seed = FP_ZERO;
`endif

  // The state is the counter seen as "group open or not"
  assign w_state = (r_cnt == '0) ? ST_IDLE : ST_ACCUM;
  // The first term of a group adds to the seed, later terms to acc
  assign w_op_a  = (w_state == ST_IDLE) ? w_seed : r_acc;

  FP_cong u_fp_add (
    .i_a   (w_op_a),
    .i_b   (bus.data_in),
    .o_sum (w_add)
  );

  // Next-state: flush beats a term; the last term of a group publishes
  always_comb begin
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_sum_nxt   = r_sum;
    w_valid_nxt = 1'b0;
    if (bus.flush) begin
      w_cnt_nxt = '0;
      w_acc_nxt = FP_ZERO;
    end else if (bus.valid_in) begin
      if (r_cnt == C_LAST) begin
        w_sum_nxt   = w_add;
        w_valid_nxt = 1'b1;
        w_cnt_nxt   = '0;
      end else begin
        w_acc_nxt = w_add;
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  // State and output registers; reset drops any partial group at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc   <= FP_ZERO;
      r_cnt   <= '0;
      r_sum   <= FP_ZERO;
      r_valid <= 1'b0;
    end else begin
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sum   <= w_sum_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign bus.sum_out   = r_sum;
  assign bus.valid_out = r_valid;
  assign bus.busy      = (w_state == ST_ACCUM);

endmodule : fp_accumulator

`default_nettype wire

// File: tb/tb_fp_accumulator.sv
// ============================================================================
// Module      : tb_fp_accumulator
// Description : Directed self-checking bench for fp_accumulator: a 9-term
//               instance and a 1-term instance, expected sums hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_accumulator;

  localparam logic [31:0] C_ONE   = 32'h3F800000;
  localparam logic [31:0] C_TWO   = 32'h40000000;
  localparam logic [31:0] C_THREE = 32'h40400000;
  localparam logic [31:0] C_MONE  = 32'hBF800000;
  localparam logic [31:0] C_NINE  = 32'h41100000;
  localparam logic [31:0] C_18    = 32'h41900000;
  localparam logic [31:0] C_MNINE = 32'hC1100000;
`ifdef FP_ACC_BIAS_EN
  localparam logic [31:0] C_HALF  = 32'h3F000000;
  localparam logic [31:0] C_N1SUM = 32'h40200000;   // 0.5 + 2.0
`else
  localparam logic [31:0] C_N1SUM = 32'h40000000;   // 0.0 + 2.0
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fp_accumulator_if bus  ();
  fp_accumulator_if bus1 ();

  fp_accumulator #(.N_TERMS(9)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
  fp_accumulator #(.N_TERMS(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_pulse  = 0;
  int          pulse_cyc [$];
  logic [31:0] pulse_sum [$];

  // Record every pulse of the 9-term instance with its cycle and value
  always @(negedge clk) begin
    cyc++;
    if (bus.valid_out === 1'b1) begin
      n_pulse++;
      pulse_cyc.push_back(cyc);
      pulse_sum.push_back(bus.sum_out);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of the 9-term stream just after the falling edge
  task automatic step(input logic v, input logic [31:0] d, input logic f);
    @(negedge clk);
    #1;
    bus.valid_in = v;
    bus.data_in  = d;
    bus.flush    = f;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int np0;
    int gap;
    bus.valid_in  = 1'b0; bus.data_in  = '0; bus.flush  = 1'b0;
    bus1.valid_in = 1'b0; bus1.data_in = '0; bus1.flush = 1'b0;
`ifdef FP_ACC_BIAS_EN
    bus.bias_in  = '0;
    bus1.bias_in = C_HALF;
`endif

    // ---- reset values
    repeat (3) step(1'b0, '0, 1'b0);
    check("rst_sum",   bus.sum_out,            32'h0);
    check("rst_valid", {31'd0, bus.valid_out}, 32'h0);
    check("rst_busy",  {31'd0, bus.busy},      32'h0);
    check("rst_n1_valid", {31'd0, bus1.valid_out}, 32'h0);
    reset = 1'b0;
    step(1'b0, '0, 1'b0);

    // ---- nine 1.0 back to back
    np0 = n_pulse;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, C_ONE, 1'b0);
      if (i == 4) check("busy_mid", {31'd0, bus.busy}, 32'h1);
      if (i == 8) check("no_early_pulse", {31'd0, bus.valid_out}, 32'h0);
    end
    step(1'b0, '0, 1'b0);
    check("g1_valid", {31'd0, bus.valid_out}, 32'h1);
    check("g1_sum",   bus.sum_out, C_NINE);
    check("g1_busy",  {31'd0, bus.busy}, 32'h0);
    step(1'b0, '0, 1'b0);
    check("g1_pulse_1cyc", {31'd0, bus.valid_out}, 32'h0);
    check("g1_npulse", 32'(n_pulse - np0), 32'd1);

    // ---- two groups back to back: 1.0 x9 then 2.0 x9
    np0 = n_pulse;
    for (int i = 0; i < 9; i++) step(1'b1, C_ONE, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, C_TWO, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    check("b2b_npulse", 32'(n_pulse - np0), 32'd2);
    if (n_pulse - np0 == 2) begin
      check("b2b_sum0",    pulse_sum[pulse_sum.size()-2], C_NINE);
      check("b2b_sum1",    pulse_sum[pulse_sum.size()-1], C_18);
      check("b2b_spacing", 32'(pulse_cyc[pulse_cyc.size()-1] - pulse_cyc[pulse_cyc.size()-2]), 32'd9);
    end
    check("b2b_sum_held", bus.sum_out, C_18);

    // ---- nine 1.0 with random idle gaps
    np0 = n_pulse;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, C_ONE, 1'b0);
      gap = $urandom_range(0, 3);
      for (int k = 0; k < gap; k++) step(1'b0, '0, 1'b0);
    end
    repeat (4) step(1'b0, '0, 1'b0);
    check("gap_npulse", 32'(n_pulse - np0), 32'd1);
    if (n_pulse - np0 == 1)
      check("gap_sum", pulse_sum[pulse_sum.size()-1], C_NINE);
    check("gap_sum_held", bus.sum_out, C_NINE);

    // ---- flush after four 3.0, term present in the flush cycle
    np0 = n_pulse;
    for (int i = 0; i < 4; i++) step(1'b1, C_THREE, 1'b0);
    step(1'b1, C_THREE, 1'b1);
    step(1'b0, '0, 1'b0);
    check("flush_busy",  {31'd0, bus.busy},      32'h0);
    check("flush_valid", {31'd0, bus.valid_out}, 32'h0);
    check("flush_sum",   bus.sum_out, C_NINE);
    for (int i = 0; i < 9; i++) step(1'b1, C_MONE, 1'b0);
    step(1'b0, '0, 1'b0);
    check("neg_valid", {31'd0, bus.valid_out}, 32'h1);
    check("neg_sum",   bus.sum_out, C_MNINE);
    step(1'b0, '0, 1'b0);
    check("flush_npulse", 32'(n_pulse - np0), 32'd1);

    // ---- asynchronous reset after five terms
    np0 = n_pulse;
    for (int i = 0; i < 5; i++) step(1'b1, C_ONE, 1'b0);
    step(1'b0, '0, 1'b0);
    check("prerst_busy", {31'd0, bus.busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("arst_busy",  {31'd0, bus.busy},      32'h0);
    check("arst_sum",   bus.sum_out,            32'h0);
    check("arst_valid", {31'd0, bus.valid_out}, 32'h0);
    step(1'b0, '0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) step(1'b1, C_ONE, 1'b0);
    step(1'b0, '0, 1'b0);
    check("postrst_sum",    bus.sum_out, C_NINE);
    check("postrst_npulse", 32'(n_pulse - np0), 32'd1);

`ifdef FP_ACC_BIAS_EN
    // ---- bias seed 0.5 with nine 1.0
    bus.bias_in = C_HALF;
    for (int i = 0; i < 9; i++) step(1'b1, C_ONE, 1'b0);
    step(1'b0, '0, 1'b0);
    bus.bias_in = '0;
    check("bias_valid", {31'd0, bus.valid_out}, 32'h1);
    check("bias_sum",   bus.sum_out, 32'h41180000);
`endif

    // ---- single-term groups: every valid term is a result
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      bus1.valid_in = 1'b1;
      bus1.data_in  = C_TWO;
      if (i > 0) begin
        check("n1_valid", {31'd0, bus1.valid_out}, 32'h1);
        check("n1_sum",   bus1.sum_out, C_N1SUM);
        check("n1_busy",  {31'd0, bus1.busy}, 32'h0);
      end
    end
    @(negedge clk);
    #1;
    bus1.valid_in = 1'b0;
    check("n1_last_valid", {31'd0, bus1.valid_out}, 32'h1);
    @(negedge clk);
    #1;
    check("n1_idle_valid", {31'd0, bus1.valid_out}, 32'h0);
    check("n1_sum_held",   bus1.sum_out, C_N1SUM);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fp_accumulator

`default_nettype wire
